// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
//   Shared types and defaults for the fetch-stage next-PC controller.
//   - state_e : sequencer FSM states (BOOT, RUN, FLUSH)
//   - sel_e   : next-PC source select
//   - DEF_*   : default vectors and flush length
// -----------------------------------------------------------------------------
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_HOLD,
    SEL_EXC
  } sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int unsigned DEF_FLUSH_CYCLES = 1;

endpackage

// File: rtl/pc_sequencer_pcadder.sv
// -----------------------------------------------------------------------------
// PCAdder
//   Sequential fetch-address incrementer (PC + 4, wraps modulo 2^32).
//   Ports:
//     PCResult    in  32  current PC
//     PCAddResult out 32  PCResult + 4, combinational
// -----------------------------------------------------------------------------
module PCAdder (
  input  logic [31:0] PCResult,
  output logic [31:0] PCAddResult
);

  assign PCAddResult = PCResult + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Next-PC controller for the fetch stage. Owns the PC register, selects
//   sequential / branch / jump / hold, and raises Flush for FLUSH_CYCLES
//   cycles after any redirect.
//   Optional feature macro: PC_SEQ_ALIGN_TRAP_EN
//     defined   -> misaligned targets redirect to EXC_VECTOR, pulse AddrErr
//                  and capture the raw target in BadAddr.
//     undefined -> target bits [1:0] are masked off; AddrErr/BadAddr absent.
//   Ports:
//     Clk           in   1  rising-edge clock
//     Reset         in   1  synchronous, active-high
//     Stall         in   1  hold PC this cycle
//     BranchTaken   in   1  branch resolved taken
//     BranchTarget  in  32  branch destination
//     Jump          in   1  jump decoded
//     JumpTarget    in  32  jump destination
//     PCResult      out 32  current fetch address
//     PCPlus4       out 32  PCResult + 4 (combinational)
//     FetchValid    out  1  PCResult is a real fetch
//     AddrErr       out  1  misaligned-target pulse (macro only)
//     BadAddr       out 32  captured misaligned target (macro only)
//     Flush         out  1  squash IF/ID this cycle
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] PCResult,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
`ifdef PC_SEQ_ALIGN_TRAP_EN
  output logic        AddrErr,
  output logic [31:0] BadAddr,
`endif
  output logic        Flush
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

`ifdef PC_SEQ_ALIGN_TRAP_EN
  localparam logic [31:0] TGT_MASK = '1;
`else
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFC;
`endif

  state_e      state_q, state_d;
  sel_e        sel;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        fv_q, fv_d;
  logic        flush_q, flush_d;
  logic        redirect;
  logic        tgt_bad;

  assign redirect = BranchTaken | Jump;

`ifdef PC_SEQ_ALIGN_TRAP_EN
  logic [31:0] tgt_raw;
  logic        ae_q, ae_d;
  logic [31:0] bad_q, bad_d;

  assign tgt_raw = BranchTaken ? BranchTarget : JumpTarget;
  assign tgt_bad = |tgt_raw[1:0];
`else
  assign tgt_bad = 1'b0;
`endif

  PCAdder u_pc_adder (
    .PCResult    (pc_q),
    .PCAddResult (PCPlus4)
  );

  // Source select: branch is older than jump, and any redirect overrides Stall.
  always_comb begin
    sel = SEL_HOLD;
    if (state_q != BOOT) begin
      if (redirect) begin
        if (tgt_bad)          sel = SEL_EXC;
        else if (BranchTaken) sel = SEL_BR;
        else                  sel = SEL_JMP;
      end else if (!Stall) begin
        sel = SEL_SEQ;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_SEQ:  pc_d = PCPlus4;
      SEL_BR:   pc_d = BranchTarget & TGT_MASK;
      SEL_JMP:  pc_d = JumpTarget & TGT_MASK;
      SEL_HOLD: pc_d = pc_q;
      SEL_EXC:  pc_d = EXC_VECTOR;
      default:  pc_d = pc_q;
    endcase
  end

  // Flush counter ticks down regardless of Stall; a redirect reloads it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, FLUSH: begin
        if (redirect) begin
          cnt_d   = FLUSH_LOAD;
          state_d = FLUSH;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - 2'd1;
          state_d = (cnt_d == '0) ? RUN : FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        cnt_d   = '0;
      end
    endcase
    flush_d = (cnt_d != '0);
    fv_d    = (state_d != BOOT);
  end

`ifdef PC_SEQ_ALIGN_TRAP_EN
  always_comb begin
    ae_d  = (sel == SEL_EXC);
    bad_d = (sel == SEL_EXC) ? tgt_raw : bad_q;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      flush_q <= 1'b0;
`ifdef PC_SEQ_ALIGN_TRAP_EN
      ae_q    <= 1'b0;
      bad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      flush_q <= flush_d;
`ifdef PC_SEQ_ALIGN_TRAP_EN
      ae_q    <= ae_d;
      bad_q   <= bad_d;
`endif
    end
  end

  assign PCResult   = pc_q;
  assign FetchValid = fv_q;
  assign Flush      = flush_q;
`ifdef PC_SEQ_ALIGN_TRAP_EN
  assign AddrErr    = ae_q;
  assign BadAddr    = bad_q;
`endif

endmodule
